// File: rtl/vga_frame_scanout_pkg.sv
// rtl/vga_frame_scanout_pkg.sv - shared 640x480@60Hz timing constants
// Horizontal figures are in pixels; vertical figures are in lines.
package vga_frame_scanout_pkg;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;

    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int VGA_FB_SPAN = 256;

endpackage

// File: rtl/vga_sync_counter.sv
// rtl/vga_sync_counter.sv - pixel enable, column/row counters and sync/active decode
// Decode outputs are combinational from the counters; the top registers them.
module vga_sync_counter
    import vga_frame_scanout_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_pix_en,
    output logic [9:0] o_col,
    output logic [9:0] o_row,
    output logic       o_active,
    output logic       o_hsync_n,
    output logic       o_vsync_n,
    output logic       o_frame_start
);

    localparam logic [9:0] L_H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] L_V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] L_H_VIS    = 10'(H_VIS);
    localparam logic [9:0] L_V_VIS    = 10'(V_VIS);
    localparam logic [9:0] L_HS_BEGIN = 10'(H_VIS + H_FP);
    localparam logic [9:0] L_HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] L_VS_BEGIN = 10'(V_VIS + V_FP);
    localparam logic [9:0] L_VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    logic       r_pix_en;
    logic [9:0] r_col;
    logic [9:0] r_row;
    logic       r_frame_start;
    logic       w_col_last;
    logic       w_row_last;

    assign w_col_last = (r_col == L_H_LAST);
    assign w_row_last = (r_row == L_V_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pix_en      <= 1'b0;
            r_col         <= '0;
            r_row         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_en      <= ~r_pix_en;
            // High only for the Clock right after the (last,last) -> (0,0) wrap.
            r_frame_start <= r_pix_en && w_col_last && w_row_last;
            if (r_pix_en) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 10'd1;
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
        end
    end

    assign o_pix_en      = r_pix_en;
    assign o_col         = r_col;
    assign o_row         = r_row;
    assign o_frame_start = r_frame_start;
    assign o_active      = (r_col < L_H_VIS) && (r_row < L_V_VIS);
    assign o_hsync_n     = !((r_col >= L_HS_BEGIN) && (r_col < L_HS_END));
    assign o_vsync_n     = !((r_row >= L_VS_BEGIN) && (r_row < L_VS_END));

endmodule

// File: rtl/vga_frame_scanout.sv
// rtl/vga_frame_scanout.sv - 256x256 frame-buffer scanout onto VGA timing
// Window compare, read-address register and a two-enable output pipeline.
module vga_frame_scanout
    import vga_frame_scanout_pkg::*;
#(
    parameter logic [9:0] WIN_ROW0     = 10'd112,
    parameter logic [9:0] WIN_COL0     = 10'd192,
    parameter logic [2:0] BORDER_COLOR = 3'b000,
    parameter int         H_VIS        = VGA_H_VIS,
    parameter int         H_FP         = VGA_H_FP,
    parameter int         H_SYNC       = VGA_H_SYNC,
    parameter int         H_BP         = VGA_H_BP,
    parameter int         V_VIS        = VGA_V_VIS,
    parameter int         V_FP         = VGA_V_FP,
    parameter int         V_SYNC       = VGA_V_SYNC,
    parameter int         V_BP         = VGA_V_BP
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oReadAddress,
    input  logic [2:0]  iReadData,
    output logic        oVGA_R,
    output logic        oVGA_G,
    output logic        oVGA_B,
    output logic        oVGA_HSync,
    output logic        oVGA_VSync,
    output logic [9:0]  oCurrentRow,
    output logic [9:0]  oCurrentCol,
    output logic        oFrameStart
);

    logic       w_pix_en;
    logic [9:0] w_col;
    logic [9:0] w_row;
    logic       w_active;
    logic       w_hsync_n;
    logic       w_vsync_n;
    logic [9:0] w_row_off;
    logic [9:0] w_col_off;
    logic       w_hit;

    logic [15:0] r_addr;
    logic        r_hit1;
    logic        r_act1;
    logic        r_hs1;
    logic        r_vs1;
    logic [2:0]  r_rgb;
    logic        r_hs;
    logic        r_vs;

    vga_sync_counter #(
        .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
        .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
    ) u_sync (
        .i_clk         (Clock),
        .i_rst         (Reset),
        .o_pix_en      (w_pix_en),
        .o_col         (w_col),
        .o_row         (w_row),
        .o_active      (w_active),
        .o_hsync_n     (w_hsync_n),
        .o_vsync_n     (w_vsync_n),
        .o_frame_start (oFrameStart)
    );

    // Offset bits [9:8] clear means the counter lies within the 256-wide span.
    assign w_row_off = w_row - WIN_ROW0;
    assign w_col_off = w_col - WIN_COL0;
    assign w_hit     = (w_row >= WIN_ROW0) && (w_row_off[9:8] == 2'b00) &&
                       (w_col >= WIN_COL0) && (w_col_off[9:8] == 2'b00);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_addr <= '0;
            r_hit1 <= 1'b0;
            r_act1 <= 1'b0;
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_rgb  <= 3'b000;
            r_hs   <= 1'b1;
            r_vs   <= 1'b1;
        end else if (w_pix_en) begin
            r_hit1 <= w_hit;
            r_act1 <= w_active;
            r_hs1  <= w_hsync_n;
            r_vs1  <= w_vsync_n;
            if (w_hit) begin
                r_addr <= {w_row_off[7:0], w_col_off[7:0]};
            end
            // iReadData answers the address registered on the previous enable.
            if (!r_act1) begin
                r_rgb <= 3'b000;
            end else if (r_hit1) begin
                r_rgb <= iReadData;
            end else begin
                r_rgb <= BORDER_COLOR;
            end
            r_hs <= r_hs1;
            r_vs <= r_vs1;
        end
    end

    assign oReadAddress = r_addr;
    assign {oVGA_R, oVGA_G, oVGA_B} = r_rgb;
    assign oVGA_HSync  = r_hs;
    assign oVGA_VSync  = r_vs;
    assign oCurrentRow = w_row;
    assign oCurrentCol = w_col;

endmodule
